// File: rtl/tape_player.sv
// Level II style cassette playback: tape RAM bytes are shifted out MSB-first as sync/data pulses
// on the latched port $FF tape input. Define TAPE_TURBO_EN to add a turbo input (advance every clock).
module tape_player #(
  parameter int AW       = 17,
  parameter int SYNC_LEN = 512,
  parameter int BIT_POS  = 1791,
  parameter int BIT_LEN  = 512,
  parameter int PERIOD   = 3593
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ce,
`ifdef TAPE_TURBO_EN
  input  logic          turbo,
`endif
  input  logic          dn_go,
  input  logic          dn_wr,
  input  logic [AW-1:0] dn_addr,
  input  logic          motor,
  input  logic          play,
  input  logic          latch_clr,
  output logic [AW-1:0] ram_a,
  input  logic [7:0]    ram_q,
  output logic          tape_in,
  output logic          bit_val,
  output logic          busy,
  output logic          eot
);

  localparam logic [11:0] SYNC_END  = 12'(SYNC_LEN);
  localparam logic [11:0] BIT_AT    = 12'(BIT_POS);
  localparam logic [11:0] PULSE_END = 12'(BIT_POS + BIT_LEN);
  localparam logic [11:0] CNT_LAST  = 12'(PERIOD - 1);
  localparam logic [AW:0]   ONE_L   = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_A   = AW'(1);

  typedef enum logic [1:0] {IDLE, PREFETCH, RUN} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW:0]   len;
  logic          dn_go_d;
  logic [11:0]   cnt;
  logic [2:0]    bptr;
  logic [7:0]    sh;
  logic          pf_wait;
  logic          last_byte;
  logic          eot_lock;
  logic          vld_p1;
  logic          vld_p2;
  logic          dn_rise;
  logic          run_ok;
  logic          start;
  logic          abort;
  logic          adv;
  logic          cell_end;

  function automatic logic [AW:0] len_max(input logic [AW:0] a, input logic [AW:0] b);
    return (a > b) ? a : b;
  endfunction

  assign dn_rise  = dn_go & ~dn_go_d;
  assign run_ok   = motor & play & ~dn_go & (len != '0);
  assign start    = run_ok & ~eot_lock;
  assign abort    = ~motor | dn_go;
`ifdef TAPE_TURBO_EN
  assign adv      = ce | turbo;
`else
  assign adv      = ce;
`endif
  assign cell_end = adv && (cnt == CNT_LAST);

  // Download length: a new download restarts the high-water mark from zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      len     <= '0;
      dn_go_d <= 1'b0;
    end else begin
      dn_go_d <= dn_go;
      if (dn_wr)
        len <= len_max(dn_rise ? '0 : len, {1'b0, dn_addr} + ONE_L);
      else if (dn_rise)
        len <= '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = PREFETCH;
      PREFETCH: if (abort) state_nxt = IDLE;
                else if (!pf_wait) state_nxt = RUN;
      RUN:      if (abort || (cell_end && last_byte)) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ram_a     <= '0;
      bptr      <= 3'd7;
      cnt       <= '0;
      eot       <= 1'b0;
      eot_lock  <= 1'b0;
      bit_val   <= 1'b0;
      tape_in   <= 1'b0;
      pf_wait   <= 1'b0;
      last_byte <= 1'b0;
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      vld_p2 <= vld_p1;
      if (!play)
        eot_lock <= 1'b0;
      if (latch_clr)
        tape_in <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ram_a     <= '0;
            bptr      <= 3'd7;
            cnt       <= '0;
            eot       <= 1'b0;
            pf_wait   <= 1'b1;
            last_byte <= 1'b0;
          end
        end
        PREFETCH: begin
          if (!abort)
            pf_wait <= 1'b0;
        end
        RUN: begin
          if (!abort && adv) begin
            if (cnt < SYNC_END)
              tape_in <= 1'b1;
            if ((cnt > BIT_AT) && (cnt < PULSE_END) && bit_val)
              tape_in <= 1'b1;
            if (cnt == BIT_AT) begin
              bit_val <= sh[bptr];
              if (bptr == 3'd0) begin
                bptr  <= 3'd7;
                ram_a <= ram_a + ONE_A;
                if (({1'b0, ram_a} + ONE_L) == len)
                  last_byte <= 1'b1;
                else
                  vld_p1 <= 1'b1;
              end else begin
                bptr <= bptr - 3'd1;
              end
            end
            if (cnt == CNT_LAST) begin
              cnt <= '0;
              if (last_byte) begin
                eot      <= 1'b1;
                eot_lock <= 1'b1;
              end
            end else begin
              cnt <= cnt + 12'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Stage p2: ram_q now reflects the address issued two clocks earlier.
  always_ff @(posedge clock) begin
    if (((state == PREFETCH) && !pf_wait) || vld_p2)
      sh <= ram_q;
  end

endmodule

// File: doc/tape_player.md
Name: tape_player

Overview:
- Sequences cassette playback from the 128 KB tape RAM into the port $FF tape input path.
- Records download length, fetches bytes on demand and serialises them MSB-first.
- Timing is Level II style: a fixed sync pulse, then an optional data pulse per bit, counted in CPU cycles (`ce`).
- Sits between the tape RAM and the port $FF read mux. The parent design muxes `ram_a` with the downloader address.

Parameters:
- AW, 17, tape RAM address width.
- SYNC_LEN, 512, CPU cycles the sync pulse is held high, counted from cycle 0.
- BIT_POS, 1791, cycle at which the data bit is sampled.
- BIT_LEN, 512, CPU cycles the data pulse is held high when the bit is 1.
- PERIOD, 3593, CPU cycles per bit cell; the counter runs 0..PERIOD-1.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- ce  in  1  CPU cycle enable (pe2M2).
- dn_go  in  1  download in progress.
- dn_wr  in  1  download byte strobe.
- dn_addr  in  AW  download byte address.
- motor  in  1  cassette motor bit (port $FF write, bit 2).
- play  in  1  play request, level.
- latch_clr  in  1  single-clock pulse on a CPU write to port $FF.
- ram_a  out  AW  playback read address.
- ram_q  in  8  tape RAM data; valid one clock after `ram_a` changes.
- tape_in  out  1  latched tape level for port $FF bit 7.
- bit_val  out  1  last sampled data bit.
- busy  out  1  state is PREFETCH or RUN.
- eot  out  1  end of tape reached; sticky.

Behaviour:
- **Reset:** everything cleared. State IDLE, `ram_a`=0, `tape_in`=0, `bit_val`=0, `busy`=0, `eot`=0, `len`=0, cycle count `cnt`=0, bit pointer `bptr`=7.
- **Length capture:**
  - Any clock with `dn_wr`=1: `len` <= max(`len`, `dn_addr`+1).
  - A rising edge of `dn_go` clears `len` to 0 on the same clock.
- **Start condition:** `run_ok` = `motor` & `play` & ~`dn_go` & (`len`≠0).
- **IDLE:**
  - If `run_ok`: `ram_a`<=0, `bptr`<=7, `cnt`<=0, `eot`<=0, go to PREFETCH.
- **PREFETCH (2 clocks, independent of `ce`):**
  - Clock 1: wait for RAM latency.
  - Clock 2: `sh`<=`ram_q`, go to RUN.
- **RUN (advances only on `ce`):**
  - `cnt`<`SYNC_LEN`: `tape_in`<=1.
  - `cnt`==`BIT_POS`: `bit_val`<=`sh[bptr]`.
    - If `bptr`==0: `bptr`<=7 and `ram_a`<=`ram_a`+1.
    - Otherwise: `bptr`<=`bptr`-1.
  - `BIT_POS`<`cnt`<`BIT_POS`+`BIT_LEN` and `bit_val`=1: `tape_in`<=1.
  - `cnt`==`PERIOD`-1: `cnt`<=0, otherwise `cnt`<=`cnt`+1.
  - **Refetch:** on the second clock after `ram_a` increments, `sh`<=`ram_q`. This must complete before the next `BIT_POS`.
  - **End of tape:** if the incremented `ram_a` equals `len`, take no refetch. At the next `cnt`==`PERIOD`-1 go to IDLE with `eot`<=1. The final bit's data pulse still completes.
- **`tape_in` hold and clear:**
  - `tape_in` is never cleared by the counter.
  - `tape_in` clears only on `latch_clr`.
  - If `latch_clr` and a set occur on the same clock, set wins.
- **Aborts:**
  - If `motor`=0 or `dn_go`=1 in PREFETCH or RUN: go to IDLE next clock. `cnt`, `bptr` and `ram_a` are held, not rewound. `eot` is unchanged.
  - Re-entering RUN from IDLE always restarts from address 0.
- **After end of tape:**
  - `eot`=1 holds IDLE until `play` falls.
  - Then it clears on the next start.
- **Busy:** `busy` is combinational from state.
- **Widths:** `cnt` is 12 bit. `ram_a` wraps at 2^AW, but `len` ≤ 2^AW bounds it first.

Optional Feature:
- Macro: **TAPE_TURBO_EN**.
- When defined:
  - Adds input `turbo` (1 bit).
  - While `turbo`=1, RUN advances every clock instead of on `ce`.
  - All cycle counts are unchanged, so the bit cell shrinks to 3593 clocks.
  - The refetch still takes 2 clocks, which is safe because `BIT_POS` > 2.
- When undefined: no `turbo` port; RUN advances only on `ce`.

Test Plan:
- Download 2 bytes 0xA5, 0x00 (`dn_addr` 0, 1); `motor`=1, `play`=1.
  - `busy` rises within 1 clock.
  - `tape_in` sets at `ce` #1.
  - `bit_val` sequence is 1,0,1,0,0,1,0,1 then 0×8.
  - `eot`=1 after 16×3593 `ce` pulses.
- Pulse `latch_clr` every 100 `ce` during bit value 1.
  - `tape_in` is 1 on the clock after each clear while `cnt`<512 or 1791<`cnt`<2303.
  - It stays 0 at `cnt`=1000 and `cnt`=3000.
- Drop `motor` at `cnt`=2000 of bit 3.
  - IDLE on the next clock, `busy`=0, `eot`=0.
  - Re-raise `motor`: `ram_a` restarts at 0, first `bit_val` equals bit 7 of byte 0.
- Assert `dn_go` mid-RUN with download of 1 byte 0xFF.
  - `len` becomes 1; playback aborts.
  - After `dn_go` falls, 8 ones are played, then `eot`.
- `len`=0 (no download), `motor`=`play`=1 → remains IDLE, `busy`=0, `ram_a`=0.
- With **TAPE_TURBO_EN** and `turbo`=1, 1 byte 0x80 → `bit_val`=1 at clock 2+1791, `eot` at clock 2+8×3593 (±1).
